triangle_setup: RTL and testbench

TRIANGLE_SETUP -- requirements
Module: triangle_setup

---
 rtl/gpu_setup_pkg.sv | 17 +
 rtl/edge_calc.sv | 23 ++
 rtl/triangle_setup.sv | 165 ++++++++++++++++
 tb/tb_triangle_setup.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_setup_pkg.sv
// Shared widths and FSM state encoding for the triangle setup slice.
package gpu_setup_pkg;
  localparam int COORD_W = 16;
  localparam int COEF_W  = 17;
  localparam int CONST_W = 33;
  localparam int AREA_W  = 35;

  typedef enum logic [2:0] {
    IDLE,
    EDGE0,
    EDGE1,
    EDGE2,
    AREA,
    NORM,
    OUT
  } state_t;
endpackage

// File: rtl/edge_calc.sv
// Edge equation coefficients for the directed edge vertex i -> vertex j.
// Purely combinational; A = yi-yj, B = xj-xi, C = xi*yj - xj*yi at full width.
module edge_calc
  import gpu_setup_pkg::*;
(
  input  logic [15:0]        xi,
  input  logic [15:0]        yi,
  input  logic [15:0]        xj,
  input  logic [15:0]        yj,
  output logic signed [16:0] a,
  output logic signed [16:0] b,
  output logic signed [32:0] c
);
  logic [2*COORD_W-1:0] p_ij;
  logic [2*COORD_W-1:0] p_ji;

  assign p_ij = (2*COORD_W)'(xi) * (2*COORD_W)'(yj);
  assign p_ji = (2*COORD_W)'(xj) * (2*COORD_W)'(yi);

  assign a = $signed({1'b0, yi}) - $signed({1'b0, yj});
  assign b = $signed({1'b0, xj}) - $signed({1'b0, xi});
  assign c = $signed({1'b0, p_ij}) - $signed({1'b0, p_ji});
endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: latches a triangle, computes three edge equations over three cycles,
// orients them by signed area, clamps the bbox and hands the result to the rasterizer.
module triangle_setup
  import gpu_setup_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_ready,
  input  logic [15:0]        x1,
  input  logic [15:0]        y1,
  input  logic [15:0]        x2,
  input  logic [15:0]        y2,
  input  logic [15:0]        x3,
  input  logic [15:0]        y3,
  input  logic [7:0]         TexNum,
  output logic               next_triangle,
  output logic               tri_valid,
  input  logic               tri_ready,
  output logic [15:0]        bb_xmin,
  output logic [15:0]        bb_xmax,
  output logic [15:0]        bb_ymin,
  output logic [15:0]        bb_ymax,
  output logic signed [16:0] a0,
  output logic signed [16:0] a1,
  output logic signed [16:0] a2,
  output logic signed [16:0] b0,
  output logic signed [16:0] b1,
  output logic signed [16:0] b2,
  output logic signed [32:0] c0,
  output logic signed [32:0] c1,
  output logic signed [32:0] c2,
  output logic [7:0]         tex_out,
  output logic               drop,
  output logic               busy
);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);

  state_t                     state;
  logic [COORD_W-1:0]         vx [3];
  logic [COORD_W-1:0]         vy [3];
  logic signed [COEF_W-1:0]   ea [3];
  logic signed [COEF_W-1:0]   eb [3];
  logic signed [CONST_W-1:0]  ec [3];
  logic [COORD_W-1:0]         xmin, xmax, ymin, ymax;
  logic signed [AREA_W-1:0]   s_area;

  logic [1:0]                 ei, ej;
  logic signed [COEF_W-1:0]   e_a, e_b;
  logic signed [CONST_W-1:0]  e_c;
  logic                       neg;

  // One edge_calc shared by all three edge states; the state picks the vertex pair.
  always_comb begin
    ei = 2'd0;
    ej = 2'd1;
    case (state)
      EDGE1: begin ei = 2'd1; ej = 2'd2; end
      EDGE2: begin ei = 2'd2; ej = 2'd0; end
      default: ;
    endcase
  end

  edge_calc u_edge (
    .xi (vx[ei]),
    .yi (vy[ei]),
    .xj (vx[ej]),
    .yj (vy[ej]),
    .a  (e_a),
    .b  (e_b),
    .c  (e_c)
  );

  assign neg  = s_area[AREA_W-1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      next_triangle <= 1'b0;
      tri_valid     <= 1'b0;
      drop          <= 1'b0;
      tex_out       <= '0;
      bb_xmin       <= '0;
      bb_xmax       <= '0;
      bb_ymin       <= '0;
      bb_ymax       <= '0;
      a0 <= '0; a1 <= '0; a2 <= '0;
      b0 <= '0; b1 <= '0; b2 <= '0;
      c0 <= '0; c1 <= '0; c2 <= '0;
      xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
      s_area <= '0;
      for (int k = 0; k < 3; k++) begin
        vx[k] <= '0;
        vy[k] <= '0;
        ea[k] <= '0;
        eb[k] <= '0;
        ec[k] <= '0;
      end
    end else begin
      next_triangle <= 1'b0;
      drop          <= 1'b0;
      case (state)
        IDLE: if (data_ready) begin
          vx[0] <= x1; vy[0] <= y1;
          vx[1] <= x2; vy[1] <= y2;
          vx[2] <= x3; vy[2] <= y3;
          tex_out       <= TexNum;
          next_triangle <= 1'b1;
          state         <= EDGE0;
        end
        EDGE0, EDGE1, EDGE2: begin
          ea[ei] <= e_a;
          eb[ei] <= e_b;
          ec[ei] <= e_c;
          // Each edge state folds its start vertex into the running bbox.
          if (state == EDGE0) begin
            xmin <= vx[ei]; xmax <= vx[ei];
            ymin <= vy[ei]; ymax <= vy[ei];
          end else begin
            if (vx[ei] < xmin) xmin <= vx[ei];
            if (vx[ei] > xmax) xmax <= vx[ei];
            if (vy[ei] < ymin) ymin <= vy[ei];
            if (vy[ei] > ymax) ymax <= vy[ei];
          end
          state <= (state == EDGE0) ? EDGE1 : (state == EDGE1) ? EDGE2 : AREA;
        end
        AREA: begin
          s_area <= AREA_W'(ec[0]) + AREA_W'(ec[1]) + AREA_W'(ec[2]);
          state  <= NORM;
        end
        NORM: begin
          if (s_area == '0 || xmin > X_LIM || ymin > Y_LIM) begin
            drop  <= 1'b1;
            state <= IDLE;
          end else begin
            a0 <= neg ? -ea[0] : ea[0];
            a1 <= neg ? -ea[1] : ea[1];
            a2 <= neg ? -ea[2] : ea[2];
            b0 <= neg ? -eb[0] : eb[0];
            b1 <= neg ? -eb[1] : eb[1];
            b2 <= neg ? -eb[2] : eb[2];
            c0 <= neg ? -ec[0] : ec[0];
            c1 <= neg ? -ec[1] : ec[1];
            c2 <= neg ? -ec[2] : ec[2];
            bb_xmin   <= xmin;
            bb_ymin   <= ymin;
            bb_xmax   <= (xmax > X_LIM) ? X_LIM : xmax;
            bb_ymax   <= (ymax > Y_LIM) ? Y_LIM : ymax;
            tri_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: if (tri_ready) begin
          tri_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_triangle_setup.sv
// Directed, table-driven bench for triangle_setup with hand-computed edge equations.
module tb_triangle_setup;
  logic               clk = 1'b0;
  logic               reset;
  logic               data_ready;
  logic [15:0]        x1, y1, x2, y2, x3, y3;
  logic [7:0]         TexNum;
  logic               next_triangle, tri_valid, tri_ready, drop, busy;
  logic [15:0]        bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic signed [16:0] a0, a1, a2, b0, b1, b2;
  logic signed [32:0] c0, c1, c2;
  logic [7:0]         tex_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [15:0]        x1, y1, x2, y2, x3, y3;
    logic [7:0]         tex;
    logic               exp_drop;
    logic signed [16:0] a0, a1, a2, b0, b1, b2;
    logic signed [32:0] c0, c1, c2;
    logic [15:0]        xmn, xmx, ymn, ymx;
  } vec_t;

  vec_t vecs [8];

  triangle_setup dut (
    .clk           (clk),
    .reset         (reset),
    .data_ready    (data_ready),
    .x1            (x1),
    .y1            (y1),
    .x2            (x2),
    .y2            (y2),
    .x3            (x3),
    .y3            (y3),
    .TexNum        (TexNum),
    .next_triangle (next_triangle),
    .tri_valid     (tri_valid),
    .tri_ready     (tri_ready),
    .bb_xmin       (bb_xmin),
    .bb_xmax       (bb_xmax),
    .bb_ymin       (bb_ymin),
    .bb_ymax       (bb_ymax),
    .a0            (a0),
    .a1            (a1),
    .a2            (a2),
    .b0            (b0),
    .b1            (b1),
    .b2            (b2),
    .c0            (c0),
    .c1            (c1),
    .c2            (c2),
    .tex_out       (tex_out),
    .drop          (drop),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input vec_t v);
    x1 = v.x1; y1 = v.y1; x2 = v.x2; y2 = v.y2; x3 = v.x3; y3 = v.y3;
    TexNum = v.tex;
  endtask

  task automatic chk_result(input vec_t v);
    chk("a0", a0, v.a0); chk("a1", a1, v.a1); chk("a2", a2, v.a2);
    chk("b0", b0, v.b0); chk("b1", b1, v.b1); chk("b2", b2, v.b2);
    chk("c0", c0, v.c0); chk("c1", c1, v.c1); chk("c2", c2, v.c2);
    chk("bb_xmin", bb_xmin, v.xmn); chk("bb_xmax", bb_xmax, v.xmx);
    chk("bb_ymin", bb_ymin, v.ymn); chk("bb_ymax", bb_ymax, v.ymx);
    chk("tex_out", tex_out, v.tex);
  endtask

  // One triangle with tri_ready already high: latch at edge N, result after edge N+5.
  task automatic run_vec(input vec_t v);
    int nt_cnt;
    present(v);
    data_ready = 1'b1;
    tri_ready  = 1'b1;
    tick();                         // edge N
    data_ready = 1'b0;
    chk("next_triangle@N+1", next_triangle, 1'b1);
    chk("busy@N+1", busy, 1'b1);
    nt_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (next_triangle) nt_cnt++;
      chk("no_valid_early", tri_valid, 1'b0);
    end
    chk("no_drop_early", drop, 1'b0);
    tick();                         // edge N+5
    chk("next_triangle_count", nt_cnt, 0);
    if (v.exp_drop) begin
      chk("drop_pulse", drop, 1'b1);
      chk("drop_no_valid", tri_valid, 1'b0);
      chk("drop_idle", busy, 1'b0);
      tick();
      chk("drop_one_cycle", drop, 1'b0);
      chk("drop_still_no_valid", tri_valid, 1'b0);
    end else begin
      chk("tri_valid@N+6", tri_valid, 1'b1);
      chk("no_drop", drop, 1'b0);
      chk_result(v);
      tick();                       // accepted on first OUT cycle
      chk("valid_fall", tri_valid, 1'b0);
      chk("idle_after_accept", busy, 1'b0);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{0, 0, 10, 0, 0, 10, 8'h11, 1'b0,
                0, -10, 10, 10, -10, 0, 0, 100, 0, 0, 10, 0, 10};
    vecs[1] = '{0, 0, 0, 10, 10, 0, 8'h22, 1'b0,
                10, -10, 0, 0, -10, 10, 0, 100, 0, 0, 10, 0, 10};
    vecs[2] = '{600, 400, 700, 400, 600, 500, 8'h33, 1'b0,
                0, -100, 100, 100, -100, 0, -40000, 110000, -60000, 600, 639, 400, 479};
    vecs[3] = '{0, 0, 5, 5, 10, 10, 8'h44, 1'b1,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{700, 10, 800, 10, 700, 20, 8'h55, 1'b1,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{10, 500, 20, 500, 10, 510, 8'h66, 1'b1,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{0, 0, 65535, 0, 0, 65535, 8'h77, 1'b0,
                0, -65535, 65535, 65535, -65535, 0, 0, 33'sd4294836225, 0, 0, 639, 0, 479};
    vecs[7] = '{0, 0, 0, 65535, 65535, 0, 8'h88, 1'b0,
                65535, -65535, 0, 0, -65535, 65535, 0, 33'sd4294836225, 0, 0, 639, 0, 479};

    reset = 1'b0; data_ready = 1'b0; tri_ready = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; x3 = '0; y3 = '0; TexNum = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", tri_valid, 1'b0);
    chk("rst_next", next_triangle, 1'b0);
    chk("rst_drop", drop, 1'b0);
    chk("rst_c1", c1, 33'sd0);
    chk("rst_tex", tex_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // Back-pressure: data_ready stays high, inputs switch to the next triangle.
    present(vecs[0]);
    data_ready = 1'b1;
    tri_ready  = 1'b0;
    tick();                         // edge N
    chk("bp_next", next_triangle, 1'b1);
    present(vecs[2]);
    for (int k = 1; k <= 5; k++) tick();
    chk("bp_valid", tri_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", tri_valid, 1'b1);
      chk("bp_no_next", next_triangle, 1'b0);
      chk("bp_stable_a1", a1, -17'sd10);
      chk("bp_stable_c1", c1, 33'sd100);
    end
    tri_ready = 1'b1;
    tick();                         // acceptance edge
    chk("bp_valid_fall", tri_valid, 1'b0);
    chk("bp_no_next_at_accept", next_triangle, 1'b0);
    tick();                         // IDLE relatches
    chk("bp_next_after", next_triangle, 1'b1);
    data_ready = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("bp_second_valid", tri_valid, 1'b1);
    chk_result(vecs[2]);
    tick();
    chk("bp_second_done", busy, 1'b0);

    // Reset in EDGE1 abandons the triangle silently.
    tick();
    present(vecs[2]);
    data_ready = 1'b1;
    tick();                         // edge N -> EDGE0
    data_ready = 1'b0;
    tick();                         // edge N+1 -> EDGE1
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_next", next_triangle, 1'b0);
    chk("arst_a1", a1, 17'sd0);
    chk("arst_c1", c1, 33'sd0);
    chk("arst_bbx", bb_xmax, 16'd0);
    chk("arst_tex", tex_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (drop || tri_valid || next_triangle || busy) bad++;
      end
      chk("arst_quiet", bad, 0);
    end
    v = vecs[0];
    run_vec(v);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
